// File: rtl/product_accumulator.sv
// Sums LEN consecutive unsigned 8-bit products into one saturating ACC_W-bit result,
// with valid/ready handshakes on the product input and on the frame result output.
module product_accumulator #(
   parameter int LEN   = 8,
   parameter int ACC_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [7:0]                 in_prod,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ACC_W-1:0]           out_sum,
   output logic                       out_ovf,
   output logic [$clog2(LEN+1)-1:0]   count
);

   localparam int CNT_W = $clog2(LEN+1);

   typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic [ACC_W-1:0]   sum_q, sum_d;
   logic               sum_ovf_q, sum_ovf_d;

   logic [ACC_W:0]     add_ext;
   logic [ACC_W-1:0]   acc_sat;
   logic               ovf_acc;

   // Widened add; the carry bit into position ACC_W signals saturation.
   always_comb begin
      add_ext = {1'b0, acc_q} + {{(ACC_W+1-8){1'b0}}, in_prod};
      acc_sat = add_ext[ACC_W] ? {ACC_W{1'b1}} : add_ext[ACC_W-1:0];
      ovf_acc = ovf_q | add_ext[ACC_W];
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      sum_d     = sum_q;
      sum_ovf_d = sum_ovf_q;
      if (clr) begin
         state_d = ACCUM;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (in_valid) begin
                  acc_d = acc_sat;
                  ovf_d = ovf_acc;
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q == CNT_W'(LEN-1)) begin
                     state_d   = DONE;
                     sum_d     = acc_sat;
                     sum_ovf_d = ovf_acc;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_d = ACCUM;
                  acc_d   = '0;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
               end
            end
            default: state_d = ACCUM;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ACCUM;
         acc_q     <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         sum_q     <= '0;
         sum_ovf_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         sum_q     <= sum_d;
         sum_ovf_q <= sum_ovf_d;
      end
   end

   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == DONE);
   assign out_sum   = sum_q;
   assign out_ovf   = sum_ovf_q;
   assign count     = cnt_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Two accumulators (16-bit and 10-bit) share one product stream; a negedge
// monitor pops expected frame results from per-instance queues at each handshake.
module tb_product_accumulator;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_prod = 8'd0;
   logic        out_ready = 1'b1;

   logic        in_ready_a, out_valid_a, out_ovf_a;
   logic [15:0] out_sum_a;
   logic [3:0]  count_a;
   logic        in_ready_b, out_valid_b, out_ovf_b;
   logic [9:0]  out_sum_b;
   logic [3:0]  count_b;

   int n_cmp = 0;
   int n_bad = 0;
   int q_a[$];
   int q_b[$];

   always #5 clk = ~clk;

   product_accumulator #(.LEN(8), .ACC_W(16)) dut_a (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_prod(in_prod), .out_valid(out_valid_a), .out_ready(out_ready),
      .out_sum(out_sum_a), .out_ovf(out_ovf_a), .count(count_a));

   product_accumulator #(.LEN(8), .ACC_W(10)) dut_b (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_prod(in_prod), .out_valid(out_valid_b), .out_ready(out_ready),
      .out_sum(out_sum_b), .out_ovf(out_ovf_b), .count(count_b));

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected results are packed as sum | (ovf << 20).
   always @(negedge clk) begin
      if (!rst && !clr && out_ready) begin
         if (out_valid_a) begin
            if (q_a.size() == 0) chk("a_unexpected_result", 1, 0);
            else begin
               int e;
               e = q_a.pop_front();
               $display("result a: sum=%0d ovf=%0d (exp %0d/%0d)", out_sum_a, out_ovf_a, e & 'hFFFFF, e >> 20);
               chk("a_sum", int'(out_sum_a), e & 'hFFFFF);
               chk("a_ovf", int'(out_ovf_a), e >> 20);
            end
         end
         if (out_valid_b) begin
            if (q_b.size() == 0) chk("b_unexpected_result", 1, 0);
            else begin
               int e;
               e = q_b.pop_front();
               $display("result b: sum=%0d ovf=%0d (exp %0d/%0d)", out_sum_b, out_ovf_b, e & 'hFFFFF, e >> 20);
               chk("b_sum", int'(out_sum_b), e & 'hFFFFF);
               chk("b_ovf", int'(out_ovf_b), e >> 20);
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 of the cycle after the accept.
   task automatic send(input logic [7:0] p);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_prod  = p;
      @(negedge clk);
      while (!in_ready_a && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready_a) chk("send_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic frame(input int p, input int step, input int gap_max, input bit push,
                        input int ea, input int ea_ovf, input int eb, input int eb_ovf);
      if (push) begin
         q_a.push_back(ea | (ea_ovf << 20));
         q_b.push_back(eb | (eb_ovf << 20));
      end
      for (int i = 0; i < 8; i++) begin
         if (i != 0 && gap_max > 0) begin
            repeat ($urandom_range(0, gap_max)) @(posedge clk);
            #1;
         end
         send(8'(p + i * step));
      end
      $display("frame sent: first=%0d step=%0d", p, step);
      chk("done_out_valid_a", int'(out_valid_a), 1);
      chk("done_in_ready_a", int'(in_ready_a), 0);
      chk("done_count_a", int'(count_a), 8);
      chk("done_out_valid_b", int'(out_valid_b), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset
      #12;
      chk("rst_out_valid", int'(out_valid_a), 0);
      chk("rst_out_sum", int'(out_sum_a), 0);
      chk("rst_count", int'(count_a), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_in_ready", int'(in_ready_a), 1);
      chk("rst_out_ovf", int'(out_ovf_a), 0);

      // Basic 1..8
      frame(1, 1, 0, 1'b1, 36, 0, 36, 0);
      @(posedge clk);
      #1;
      chk("basic_count_after", int'(count_a), 0);
      chk("basic_out_valid_after", int'(out_valid_a), 0);

      // Backpressure, with in_valid traffic while DONE
      out_ready = 1'b0;
      frame(10, 0, 0, 1'b1, 80, 0, 80, 0);
      in_valid = 1'b1;
      in_prod  = 8'd99;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_sum_stable", int'(out_sum_a), 80);
         chk("bp_in_ready", int'(in_ready_a), 0);
         chk("bp_count", int'(count_a), 8);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_count_after", int'(count_a), 0);
      chk("bp_out_valid_after", int'(out_valid_b), 0);

      // Saturation in the 10-bit instance, then a clean frame
      frame(225, 0, 0, 1'b1, 1800, 0, 1023, 1);
      frame(1, 0, 1, 1'b1, 8, 0, 8, 0);

      // clr mid-frame, with a product offered in the clr cycle
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) send(8'd50);
      chk("clr_count_before", int'(count_a), 3);
      clr = 1'b1;
      in_valid = 1'b1;
      in_prod = 8'd50;
      @(posedge clk);
      #1;
      clr = 1'b0;
      in_valid = 1'b0;
      chk("clr_count_after", int'(count_a), 0);
      frame(2, 0, 0, 1'b1, 16, 0, 16, 0);

      // clr while DONE discards the result but keeps out_sum
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      frame(3, 0, 0, 1'b0, 0, 0, 0, 0);
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      out_ready = 1'b1;
      chk("clr_done_out_valid", int'(out_valid_a), 0);
      chk("clr_done_count", int'(count_a), 0);
      chk("clr_done_out_sum_kept", int'(out_sum_a), 24);

      // Async reset mid-frame with gaps
      for (int i = 0; i < 4; i++) begin
         send(8'd7);
         @(posedge clk);
         #1;
      end
      chk("pre_rst_count", int'(count_a), 4);
      rst = 1'b1;
      #2;
      chk("async_rst_count", int'(count_a), 0);
      chk("async_rst_out_sum", int'(out_sum_a), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", int'(in_ready_a), 1);
      frame(225, 0, 3, 1'b1, 1800, 0, 1023, 1);

      repeat (3) @(posedge clk);
      #1;
      chk("q_a_drained", q_a.size(), 0);
      chk("q_b_drained", q_b.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
